// File: rtl/util_1553_pkg.sv
// Shared types and constants for the util_1553 pattern generator path.
package util_1553_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_GAP
  } state_e;

  typedef enum logic {
    SYNC_DATA = 1'b0,
    SYNC_CMD  = 1'b1
  } sync_e;

  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
  localparam logic [15:0] LFSR_DFLT_SEED = 16'hACE1;

  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_LFSR  = 2'b01;
  localparam logic [1:0] MODE_FIXED = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic [1:0] SYNC_SEL_DATA = 2'b00;
  localparam logic [1:0] SYNC_SEL_CMD  = 2'b01;
  localparam logic [1:0] SYNC_SEL_AUTO = 2'b10;

  // Right-shifting Fibonacci step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {^(x & LFSR_TAP_MASK), x[15:1]};
  endfunction

endpackage

// File: rtl/util_1553_word_src.sv
// Word source: count / LFSR / fixed selection, reloaded from seed at burst start.
module util_1553_word_src
  import util_1553_pkg::*;
#(
  parameter logic [15:0] SEED_DFLT = LFSR_DFLT_SEED
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [1:0]  mode_i,
  input  logic [15:0] seed_i,
  input  logic [15:0] data_i,
  output logic [15:0] word_o
);

  logic [15:0] word_q;
  logic [15:0] word_d;

  always_comb begin
    word_d = word_q;
    if (load_i || adv_i) begin
      case (mode_i)
        MODE_LFSR: begin
          if (load_i) word_d = (seed_i == 16'h0000) ? SEED_DFLT : seed_i;
          else        word_d = lfsr_step(word_q);
        end
        MODE_FIXED: word_d = data_i;
        default: begin
          if (load_i) word_d = seed_i;
          else        word_d = word_q + 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) word_q <= 16'h0000;
    else      word_q <= word_d;
  end

  assign word_o = word_q;

endmodule

// File: rtl/util_1553_pattern_gen.sv
// MIL-STD-1553 Manchester word pattern generator for loopback and BIST.
// Optional error injection ports: `UTIL_1553_PATTERN_GEN_ERR_INJECT_EN.
module util_1553_pattern_gen
  import util_1553_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED     = 50000000,
  parameter int unsigned BIT_RATE        = 1000000,
  parameter int unsigned WORD_GAP_CYCLES = 5000,
  parameter logic [15:0] LFSR_SEED_DFLT  = 16'hACE1
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [1:0]  sync_sel,
  input  logic [15:0] seed,
  input  logic [15:0] data_in,
  input  logic [7:0]  burst_len,
  output logic        tx0_1553,
  output logic        tx1_1553,
  output logic        en_diff,
  output logic        busy,
  output logic        word_done,
  output logic [15:0] word_cnt
`ifdef UTIL_1553_PATTERN_GEN_ERR_INJECT_EN
  ,
  input  logic        err_parity,
  input  logic        err_manch
`endif
);

  localparam int unsigned CPB      = CLOCK_SPEED / BIT_RATE;
  localparam int unsigned HALF     = CPB / 2;
  localparam int unsigned SYNC_CYC = 3 * CPB;
  localparam int unsigned CNT_MAX  = (SYNC_CYC > WORD_GAP_CYCLES) ? SYNC_CYC : WORD_GAP_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        bit_q;
  logic              armed_q;
  logic [7:0]        burst_q;
  logic [7:0]        burst_len_q;
  logic [1:0]        sync_sel_q;
  logic              par_pend_q, manch_pend_q, par_err_q, manch_err_q;
  logic              tx0_q, tx1_q, en_q, busy_q, done_q;
  logic [15:0]       word_cnt_q;

  logic [15:0] word;
  sync_e       sync_kind_c;
  logic        data_bit_c, parity_c, first_half_c, line_c, active_c, phase_end_c;
  logic        word_end_c, burst_done_c, start_c, adv_c, enter_sync_c;
  logic        par_req_c, manch_req_c;

`ifdef UTIL_1553_PATTERN_GEN_ERR_INJECT_EN
  assign par_req_c   = err_parity;
  assign manch_req_c = err_manch;
`else
  assign par_req_c   = 1'b0;
  assign manch_req_c = 1'b0;
`endif

  util_1553_word_src #(
    .SEED_DFLT (LFSR_SEED_DFLT)
  ) u_word_src (
    .aclk   (aclk),
    .arst   (arst),
    .load_i (start_c),
    .adv_i  (adv_c),
    .mode_i (mode),
    .seed_i (seed),
    .data_i (data_in),
    .word_o (word)
  );

  // Line encoder and sequencing strobes, from the current state.
  always_comb begin
    sync_kind_c  = ((sync_sel_q == SYNC_SEL_CMD) || (sync_sel_q[1] && (^word))) ? SYNC_CMD : SYNC_DATA;
    data_bit_c   = word[4'd15 - bit_q];
    parity_c     = ~(^word) ^ par_err_q;
    first_half_c = cnt_q < CNT_W'(HALF);
    line_c       = 1'b0;
    active_c     = 1'b0;
    phase_end_c  = 1'b0;
    case (state_q)
      ST_SYNC: begin
        active_c    = 1'b1;
        line_c      = (cnt_q < CNT_W'(SYNC_CYC / 2)) ? (sync_kind_c == SYNC_CMD) : (sync_kind_c == SYNC_DATA);
        phase_end_c = cnt_q == CNT_W'(SYNC_CYC - 1);
      end
      ST_DATA: begin
        active_c    = 1'b1;
        line_c      = (first_half_c || (manch_err_q && bit_q == 4'd0)) ? data_bit_c : ~data_bit_c;
        phase_end_c = cnt_q == CNT_W'(CPB - 1);
      end
      ST_PARITY: begin
        active_c    = 1'b1;
        line_c      = first_half_c ? parity_c : ~parity_c;
        phase_end_c = cnt_q == CNT_W'(CPB - 1);
      end
      ST_GAP:  phase_end_c = cnt_q == CNT_W'(WORD_GAP_CYCLES - 1);
      default: ;
    endcase
    word_end_c   = (state_q == ST_PARITY && phase_end_c && WORD_GAP_CYCLES == 0) ||
                   (state_q == ST_GAP && phase_end_c);
    burst_done_c = (burst_len_q != 8'd0) && (burst_q == burst_len_q);
    start_c      = (state_q == ST_IDLE) && enable && armed_q;
    adv_c        = word_end_c && enable && !burst_done_c;
    enter_sync_c = start_c || adv_c;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= 4'd0;
      armed_q      <= 1'b1;
      burst_q      <= 8'd0;
      burst_len_q  <= 8'd0;
      sync_sel_q   <= 2'b00;
      par_pend_q   <= 1'b0;
      manch_pend_q <= 1'b0;
      par_err_q    <= 1'b0;
      manch_err_q  <= 1'b0;
      tx0_q        <= 1'b0;
      tx1_q        <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_cnt_q   <= 16'h0000;
    end else begin
      tx0_q  <= active_c & line_c;
      tx1_q  <= active_c & ~line_c;
      en_q   <= active_c;
      busy_q <= state_q != ST_IDLE;
      done_q <= (state_q == ST_PARITY) && phase_end_c;
      if ((state_q == ST_PARITY) && phase_end_c) word_cnt_q <= word_cnt_q + 16'd1;

      // A finished burst disarms until enable is seen low again.
      if (!enable)                         armed_q <= 1'b1;
      else if (word_end_c && burst_done_c) armed_q <= 1'b0;

      par_pend_q   <= enter_sync_c ? 1'b0 : (par_pend_q | par_req_c);
      manch_pend_q <= enter_sync_c ? 1'b0 : (manch_pend_q | manch_req_c);

      if (enter_sync_c) begin
        state_q     <= ST_SYNC;
        cnt_q       <= '0;
        sync_sel_q  <= sync_sel;
        burst_len_q <= burst_len;
        burst_q     <= start_c ? 8'd1 : burst_q + 8'd1;
        par_err_q   <= par_pend_q | par_req_c;
        manch_err_q <= manch_pend_q | manch_req_c;
      end else begin
        case (state_q)
          ST_SYNC: begin
            if (phase_end_c) begin
              state_q <= ST_DATA;
              cnt_q   <= '0;
              bit_q   <= 4'd0;
            end else cnt_q <= cnt_q + CNT_W'(1);
          end
          ST_DATA: begin
            if (phase_end_c) begin
              cnt_q <= '0;
              if (bit_q == 4'd15) state_q <= ST_PARITY;
              else                bit_q   <= bit_q + 4'd1;
            end else cnt_q <= cnt_q + CNT_W'(1);
          end
          ST_PARITY: begin
            if (phase_end_c) begin
              cnt_q   <= '0;
              state_q <= word_end_c ? ST_IDLE : ST_GAP;
            end else cnt_q <= cnt_q + CNT_W'(1);
          end
          ST_GAP: begin
            if (phase_end_c) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else cnt_q <= cnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign tx0_1553  = tx0_q;
  assign tx1_1553  = tx1_q;
  assign en_diff   = en_q;
  assign busy      = busy_q;
  assign word_done = done_q;
  assign word_cnt  = word_cnt_q;

endmodule
